// File: rtl/tlb_pkg.sv
// Shared definitions for the TLB instruction sequencer: op codes, FSM states,
// default TLB size and the position of the Index P (probe-failure) bit.
package tlb_pkg;

    localparam int TLB_ENTRIES_DFLT = 16;
    localparam int INDEX_P_BIT      = 31;

    localparam logic [2:0] TLB_OP_NOP   = 3'b000;
    localparam logic [2:0] TLB_OP_TLBR  = 3'b001;
    localparam logic [2:0] TLB_OP_TLBWI = 3'b010;
    localparam logic [2:0] TLB_OP_TLBWR = 3'b011;
    localparam logic [2:0] TLB_OP_TLBP  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } tlb_state_e;

endpackage

// File: rtl/tlb_random_ctr.sv
// CP0 Random register: free-running down-counter that wraps from Wired back to
// the top entry, and is forced to the top entry by a write to Wired.
module tlb_random_ctr #(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] cp0_wired,
    input  logic             wired_wr,
    output logic [IDX_W-1:0] random
);

    localparam logic [IDX_W-1:0] TOP = IDX_W'(TLB_ENTRIES - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            random <= TOP;
        end else if (wired_wr || (cp0_wired >= TOP) || (random == cp0_wired)) begin
            random <= TOP;
        end else begin
            random <= random - 1'b1;
        end
    end

endmodule

// File: rtl/tlb_op_ctrl.sv
// TLB instruction sequencer (IDLE -> EXEC -> WB). Optional TLBP multi-hit
// detection is built when TLB_MULTIHIT_CHK_EN is defined.
module tlb_op_ctrl
    import tlb_pkg::*;
#(
    parameter int TLB_ENTRIES = TLB_ENTRIES_DFLT,
    parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic [2:0]             req_op,
    output logic                   req_ready,
    input  logic [IDX_W-1:0]       cp0_index,
    input  logic [IDX_W-1:0]       cp0_wired,
    input  logic                   wired_wr,
    output logic [2:0]             tlb_op,
    output logic [TLB_ENTRIES-1:0] line_index_sel,
    output logic [TLB_ENTRIES-1:0] line_random_sel,
    input  logic [TLB_ENTRIES-1:0] tlbp_hit_vec,
    input  logic [31:0]            rd_entryhi,
    input  logic [31:0]            rd_entrylo0,
    input  logic [31:0]            rd_entrylo1,
    output logic                   cp0_index_we,
    output logic [31:0]            cp0_index_wdata,
    output logic                   cp0_entry_we,
    output logic [31:0]            cp0_entryhi_wdata,
    output logic [31:0]            cp0_entrylo0_wdata,
    output logic [31:0]            cp0_entrylo1_wdata,
    output logic [IDX_W-1:0]       random,
    output logic                   busy,
    output logic                   done,
    output logic                   tlbp_multi_hit
);

    tlb_state_e state;
    logic [2:0] op_q;
    logic [2:0] op_norm;

    tlb_random_ctr #(
        .TLB_ENTRIES (TLB_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_random (
        .clk       (clk),
        .rst       (rst),
        .cp0_wired (cp0_wired),
        .wired_wr  (wired_wr),
        .random    (random)
    );

    function automatic logic [2:0] norm_op(input logic [2:0] op);
        case (op)
            TLB_OP_TLBR, TLB_OP_TLBWI, TLB_OP_TLBWR, TLB_OP_TLBP: return op;
            default:                                              return TLB_OP_NOP;
        endcase
    endfunction

    function automatic logic [TLB_ENTRIES-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [TLB_ENTRIES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Scanning downward leaves the lowest set bit as the final answer.
    function automatic logic [IDX_W-1:0] lowest_hit(input logic [TLB_ENTRIES-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    assign op_norm = norm_op(req_op);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= ST_IDLE;
            op_q               <= TLB_OP_NOP;
            req_ready          <= 1'b1;
            busy               <= 1'b0;
            done               <= 1'b0;
            tlb_op             <= TLB_OP_NOP;
            line_index_sel     <= '0;
            line_random_sel    <= '0;
            cp0_index_we       <= 1'b0;
            cp0_index_wdata    <= '0;
            cp0_entry_we       <= 1'b0;
            cp0_entryhi_wdata  <= '0;
            cp0_entrylo0_wdata <= '0;
            cp0_entrylo1_wdata <= '0;
        end else begin
            case (state)
                // Accept: selects are decoded now so they are registered for EXEC.
                ST_IDLE: begin
                    if (req_valid) begin
                        state           <= ST_EXEC;
                        op_q            <= op_norm;
                        tlb_op          <= op_norm;
                        line_index_sel  <= (op_norm == TLB_OP_TLBR || op_norm == TLB_OP_TLBWI)
                                           ? onehot(cp0_index) : '0;
                        line_random_sel <= (op_norm == TLB_OP_TLBWR) ? onehot(random) : '0;
                        req_ready       <= 1'b0;
                        busy            <= 1'b1;
                    end
                end
                // End of EXEC: lines commit writes; sample read bus / hit vector.
                ST_EXEC: begin
                    state           <= ST_WB;
                    tlb_op          <= TLB_OP_NOP;
                    line_index_sel  <= '0;
                    line_random_sel <= '0;
                    done            <= 1'b1;
                    if (op_q == TLB_OP_TLBR) begin
                        cp0_entry_we       <= 1'b1;
                        cp0_entryhi_wdata  <= rd_entryhi;
                        cp0_entrylo0_wdata <= rd_entrylo0;
                        cp0_entrylo1_wdata <= rd_entrylo1;
                    end
                    if (op_q == TLB_OP_TLBP) begin
                        cp0_index_we    <= 1'b1;
                        cp0_index_wdata <= (|tlbp_hit_vec) ? 32'(lowest_hit(tlbp_hit_vec))
                                                           : (32'b1 << INDEX_P_BIT);
                    end
                end
                ST_WB: begin
                    state        <= ST_IDLE;
                    done         <= 1'b0;
                    cp0_entry_we <= 1'b0;
                    cp0_index_we <= 1'b0;
                    busy         <= 1'b0;
                    req_ready    <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef TLB_MULTIHIT_CHK_EN
    logic multi_hit_q;

    // v & (v-1) is nonzero exactly when more than one bit is set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            multi_hit_q <= 1'b0;
        end else begin
            multi_hit_q <= (state == ST_EXEC) && (op_q == TLB_OP_TLBP)
                           && (|(tlbp_hit_vec & (tlbp_hit_vec - TLB_ENTRIES'(1))));
        end
    end

    assign tlbp_multi_hit = multi_hit_q;
`else
    assign tlbp_multi_hit = 1'b0;
`endif

endmodule

// File: doc/tlb_op_ctrl.md
# tlb_op_ctrl

Sequencer between the CP0/exception stage and the array of per-entry TLB lines. Accepts one TLB instruction (TLBR, TLBWI, TLBWR, TLBP) at a time over a valid/ready handshake. Drives the shared op bus and one-hot line selects, then writes results back to CP0 Index/EntryHi/EntryLo0/EntryLo1. Also owns the CP0 Random counter that TLBWR uses to choose a victim line.

## Interface
- `TLB_ENTRIES`, 16: number of TLB lines; power of two, 4..64.
- `IDX_W`, $clog2(TLB_ENTRIES): index width.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: TLB instruction present.
- `req_op` in 3: 001 TLBR, 010 TLBWI, 011 TLBWR, 100 TLBP; other codes are NOP.
- `req_ready` out 1: high in IDLE only.
- `cp0_index` in IDX_W: CP0 Index[IDX_W-1:0].
- `cp0_wired` in IDX_W: CP0 Wired.
- `wired_wr` in 1: pulse on an MTC0 to Wired.
- `tlb_op` out 3: op bus to all lines.
- `line_index_sel` out TLB_ENTRIES: one-hot Which_line_index.
- `line_random_sel` out TLB_ENTRIES: one-hot Which_line_random.
- `tlbp_hit_vec` in TLB_ENTRIES: per-line TLBP_hit.
- `rd_entryhi`, `rd_entrylo0`, `rd_entrylo1` in 32 each: shared read bus from the lines.
- `cp0_index_we` out 1, `cp0_index_wdata` out 32: Index writeback.
- `cp0_entry_we` out 1: write strobe for EntryHi/Lo0/Lo1.
- `cp0_entryhi_wdata`, `cp0_entrylo0_wdata`, `cp0_entrylo1_wdata` out 32 each.
- `random` out IDX_W: CP0 Random value.
- `busy` out 1, `done` out 1: done is a one-cycle completion pulse.
- `tlbp_multi_hit` out 1: pulse when TLBP matches more than one line.

## Operation
- **FSM:** IDLE -> EXEC -> WB -> IDLE.
  - IDLE: `req_ready`=1. On `req_valid`, latch the op, `cp0_index`, and `random`, then go to EXEC.
- **EXEC (one cycle):**
  - `tlb_op` = latched op.
  - `line_index_sel` = onehot(latched index) for TLBR/TLBWI, else 0.
  - `line_random_sel` = onehot(latched random) for TLBWR, else 0.
  - The lines commit TLBWI/TLBWR writes on the clock edge that ends EXEC.
  - TLBR: capture the `rd_*` buses.
  - TLBP: capture `tlbp_hit_vec`.
- **WB (one cycle):** `done`=1; `tlb_op`=000; all selects 0.
  - TLBR: `cp0_entry_we`=1, with captured data on the three wdata buses.
  - TLBP, hit: `cp0_index_we`=1, `cp0_index_wdata`={1'b0, zeros, lowest hit index}.
  - TLBP, miss: `cp0_index_we`=1, `cp0_index_wdata`=32'h8000_0000 (P bit set).
  - TLBWI/TLBWR/NOP: no CP0 write.
- **Random counter:**
  - Reset value TLB_ENTRIES-1.
  - Decrements every cycle.
  - When `random` == `cp0_wired`, the next value is TLB_ENTRIES-1.
  - If `cp0_wired` >= TLB_ENTRIES-1, held at TLB_ENTRIES-1.
  - `wired_wr` forces TLB_ENTRIES-1 on the next edge; this takes priority over decrement.
  - The counter keeps running in all FSM states.
- **NOP op:** completes like the others (`done` in WB) with `tlb_op`=000 throughout.

## Timing
- Reset (async assert, sync release): state IDLE; `req_ready`=1; `random`=TLB_ENTRIES-1; every other output 0.
- Reset asserted mid-EXEC: the line write may be lost; the FSM and outputs return immediately to reset values.
- Latency: request accepted at edge N, EXEC during cycle N+1, `done` during cycle N+2, `req_ready` high again in cycle N+3.
- Throughput: one instruction per 3 cycles.
- `busy`=1 in EXEC and WB.
- `req_valid` is ignored while `busy`; the requester must hold it until accepted.
- The `rd_*` buses and `tlbp_hit_vec` are sampled only at the end of EXEC.
- `wired_wr` in the same cycle as TLBWR acceptance: TLBWR uses the pre-reset Random value.

## Configuration
- `TLB_MULTIHIT_CHK_EN` defined: `tlbp_multi_hit` pulses in WB when the captured hit vector has more than one bit set; the Index result is still the lowest index.
- Not defined: `tlbp_multi_hit` is tied 0 and no popcount logic is built.

## Structure
- Shared package `tlb_pkg`:
  - op codes: `TLB_OP_NOP`, `TLB_OP_TLBR`, `TLB_OP_TLBWI`, `TLB_OP_TLBWR`, `TLB_OP_TLBP`;
  - FSM state enum;
  - default `TLB_ENTRIES`;
  - Index P-bit position (31).
- Sub-module `tlb_random_ctr`: Random/Wired counter, instantiated once.
- Priority encoder and one-hot decode stay inline.

## Test plan
1. Reset, TLB_ENTRIES=16: `random`=15 and `req_ready`=1. Release with wired=4: random counts 15, 14 … 4, 15.
2. TLBWI with index=5: one EXEC cycle with `tlb_op`=010 and `line_index_sel`=16'h0020, then `done` one cycle later, no CP0 write.
3. TLBR with index=3 and the read bus driving EntryHi=32'h1234_A0FF: WB shows `cp0_entry_we`=1 and `cp0_entryhi_wdata`=32'h1234_A0FF.
4. TLBP:
   - hit vector 16'h0840: Index wdata=32'h0000_0006; with the macro defined, `tlbp_multi_hit`=1.
   - hit vector 0: Index wdata=32'h8000_0000.
5. TLBWR accepted while `random`=9, with `wired_wr` in the same cycle: `line_random_sel`=16'h0200, and `random` reads 15 the next cycle.
6. Reset asserted during EXEC: all outputs drop to reset values within the cycle; the FSM is in IDLE.
